// File: rtl/c499_lock_pkg.sv
// Shared constants and types for the c499 key loader: frame geometry, FSM states
// and the frame-bit position of each locked-netlist key input.
package c499_lock_pkg;

    localparam int KEY_W   = 9;
    localparam int FRAME_W = KEY_W + 1;
    localparam int CNT_W   = 4;
    localparam int PAR_IDX = FRAME_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        ARMED,
        LOCKED
    } state_t;

    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P3_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int X1_IDX = 4;
    localparam int X2_IDX = 5;
    localparam int X3_IDX = 6;
    localparam int X4_IDX = 7;
    localparam int X5_IDX = 8;

endpackage

// File: rtl/c499_key_shreg.sv
// Serial shadow register for one key frame: stores bits LSB first, counts them,
// and tracks key parity so the frame can be judged the cycle after its last bit.
module c499_key_shreg
    import c499_lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             xfer,
    input  logic             bit_in,
    output logic [KEY_W-1:0] shadow_key,
    output logic             frame_done,
    output logic             parity_ok
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_W - 1);

    logic [FRAME_W-1:0] shadow;
    logic [CNT_W-1:0]   count;
    logic               par_q;

    assign frame_done = xfer && (count == LAST);
    assign shadow_key = shadow[KEY_W-1:0];
    // par_q covers key bits only; the frame is good when it equals the parity bit.
    assign parity_ok  = (par_q == shadow[PAR_IDX]);

    // NOTE: the shadow is a plain register bank (not a RAM), so clearing it on reset costs nothing and keeps abort semantics simple.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            shadow <= '0;
            count  <= '0;
            par_q  <= 1'b0;
        end else if (xfer) begin
            for (int i = 0; i < FRAME_W; i++) begin
                if (count == CNT_W'(i)) begin
                    shadow[i] <= bit_in;
                end
            end
            if (count == '0) begin
                par_q <= bit_in;
            end else if (count != LAST) begin
                par_q <= par_q ^ bit_in;
            end
            count <= frame_done ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/c499_key_loader.sv
// Key-load stage ahead of the locked c499: accepts a parity-protected serial key,
// commits it to the p/X key inputs, gates N137, and locks out on repeated failures.
module c499_key_loader
    import c499_lock_pkg::*;
#(
    parameter int MAX_FAIL = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic       key_bit,
    output logic       key_ready,
    input  logic       abort,
    output logic       p1,
    output logic       p2,
    output logic       p3,
    output logic       p4,
    output logic       X_1,
    output logic       X_2,
    output logic       X_3,
    output logic       X_4,
    output logic       X_5,
    output logic       en_out,
    output logic       armed,
    output logic       locked,
    output logic [1:0] fail_cnt
);

    state_t           state;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] shadow_key;
    logic             xfer;
    logic             frame_done;
    logic             parity_ok;
    logic [1:0]       fail_next;

    // key_ready must not look at key_valid, otherwise the handshake would loop.
    assign key_ready = (state == IDLE || state == SHIFT || state == ARMED) && !abort;
    assign xfer      = key_valid && key_ready;
    assign fail_next = fail_cnt + 2'd1;

    c499_key_shreg u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (abort && state == SHIFT),
        .xfer       (xfer),
        .bit_in     (key_bit),
        .shadow_key (shadow_key),
        .frame_done (frame_done),
        .parity_ok  (parity_ok)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            key_q    <= '0;
            en_out   <= 1'b0;
            armed    <= 1'b0;
            locked   <= 1'b0;
            fail_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) state <= SHIFT;
                end
                SHIFT: begin
                    if (abort)           state <= IDLE;
                    else if (frame_done) state <= CHECK;
                end
                CHECK: begin
                    if (parity_ok) begin
                        key_q    <= shadow_key;
                        armed    <= 1'b1;
                        en_out   <= 1'b1;
                        fail_cnt <= '0;
                        state    <= ARMED;
                    end else begin
                        fail_cnt <= fail_next;
                        if (int'(fail_next) == MAX_FAIL) begin
                            locked <= 1'b1;
                            state  <= LOCKED;
                        end else begin
                            state  <= IDLE;
                        end
                    end
                end
                ARMED: begin
                    // A new frame revokes the enable at once; the old key stays visible.
                    if (xfer) begin
                        armed  <= 1'b0;
                        en_out <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                LOCKED: begin
                    state <= LOCKED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign p1  = key_q[P1_IDX];
    assign p2  = key_q[P2_IDX];
    assign p3  = key_q[P3_IDX];
    assign p4  = key_q[P4_IDX];
    assign X_1 = key_q[X1_IDX];
    assign X_2 = key_q[X2_IDX];
    assign X_3 = key_q[X3_IDX];
    assign X_4 = key_q[X4_IDX];
    assign X_5 = key_q[X5_IDX];

endmodule

// File: doc/c499_key_loader.md
# c499_key_loader

Sequential key-load stage that sits directly upstream of the mux4/XOR-locked c499 SEC circuit. It receives the 9-bit unlock key as a serial, parity-protected frame over a valid/ready handshake and holds it in registers that drive the locked netlist's key inputs (p1..p4, X_1..X_5). It also drives the c499 enable input N137, so the circuit only operates once a key has committed. Repeated parity failures permanently lock the loader until reset.

## Interface
- KEY_W, 9: key bits per frame (p1..p4, X_1..X_5).
- MAX_FAIL, 3: consecutive parity failures before lockout (≥1).
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- key_valid  in  1  serial bit offered.
- key_bit  in  1  serial data, frame LSB first.
- key_ready  out  1  loader accepts a bit this cycle.
- abort  in  1  discard the partial frame.
- p1, p2, p3, p4  out  1 each  committed mux4 key bits.
- X_1, X_2, X_3, X_4, X_5  out  1 each  committed XOR key bits.
- en_out  out  1  drives c499 N137.
- armed  out  1  a valid key is committed.
- locked  out  1  lockout reached.
- fail_cnt  out  2  consecutive parity failures.

## Operation
- Frame: 10 bits. Bits 0..8 are the key, bit 9 is even parity; the XOR of all 10 bits must be 0. Mapping: bit0→p1, bit1→p2, bit2→p3, bit3→p4, bits 4..8→X_1..X_5.
- A bit transfers on a clock edge with key_valid=1 and key_ready=1.
- States:
  - IDLE: key_ready=1. A transfer stores bit 0, sets bit count to 1 and goes to SHIFT.
  - SHIFT: key_ready=1. Each transfer stores the bit at index count and increments count. The transfer of bit 9 goes to CHECK.
  - CHECK: one cycle, key_ready=0.
    - Parity ok: copy the shadow key to p/X outputs, set armed=1 and en_out=1, clear fail_cnt, go to ARMED.
    - Parity bad: increment fail_cnt. Go to LOCKED if the new value equals MAX_FAIL, else IDLE. Outputs keep their previous values.
  - ARMED: key_ready=1. A transfer starts a new frame exactly as in IDLE. It also drops en_out and armed on that edge. p/X outputs hold the old key until the next successful commit.
  - LOCKED: key_ready=0, locked=1, en_out=0, armed=0. Left only by reset.
- Abort:
  - In SHIFT: clear count and the shadow register, go to IDLE. fail_cnt is unchanged.
  - In IDLE, ARMED, CHECK or LOCKED: no effect.
  - key_ready is forced to 0 while abort=1, so abort wins over a simultaneous key_valid and that bit is dropped.
- key_valid while key_ready=0: ignored; nothing is stored.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, count 0, shadow 0. All p/X outputs 0; en_out, armed, locked 0; fail_cnt 0; key_ready 1 from the first cycle after reset. Reset mid-frame or in LOCKED behaves the same.
- Throughput: one bit per cycle with key_valid held high. A full frame takes 10 accepting cycles plus 1 CHECK cycle.
- Latency: with the last bit transferred at edge k, p/X, armed and en_out update at edge k+1.
- key_ready is combinational from state and abort only; it never depends on key_valid.
- All outputs except key_ready are registered.

## Structure
- Package c499_lock_pkg holds:
  - KEY_W and FRAME_W (=KEY_W+1).
  - The state enum {IDLE, SHIFT, CHECK, ARMED, LOCKED}.
  - Key bit index constants (P1_IDX..P4_IDX, X1_IDX..X5_IDX).
- Sub-module c499_key_shreg contains the 10-bit shadow register, the 4-bit bit counter, the running-parity flop, and the clear/abort logic. It exports frame_done and parity_ok.
- The top level holds the FSM, commit registers and fail counter.

## Test plan
- Reset, then send key 0x1A5 with parity 1 (frame bits 1,0,1,0,0,1,0,1,1,1) → one cycle after the last bit: p1..p4=1,0,1,0, X_1..X_5=0,1,0,1,1, armed=en_out=1, fail_cnt=0.
- Send 0x1A5 with parity 0 → fail_cnt=1, state IDLE, en_out=0, p/X remain 0. Then send a good frame → commit and fail_cnt=0.
- Send three bad frames back to back → locked=1 and key_ready=0 after the third CHECK. A following good frame is ignored; rst_n=0 clears everything.
- After a commit of 0x1A5, start a frame of 0x0FF → en_out drops at the first transfer while p/X still show 0x1A5 until the new commit.
- Abort after 6 bits, with key_valid=1 in the same cycle → that bit is dropped and count=0. A following full frame of 0x055 commits correctly.
- Toggle key_valid randomly during a frame → only handshaken bits are stored, and the committed key matches the sent key.
